debounce_multi: RTL
===================

DEBOUNCE_MULTI -- requirements
Module: debounce_multi

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels, 1 to 32.
REQ-002 Parameter CNTSIZE, default 3: bit width of each channel's counter.
REQ-003 Parameter STABLE, default 5: debounce window in clock cycles, legal range 1 to 2^CNTSIZE-1; behaviour for other values is undefined.
REQ-004 Parameter MODE, default 0: 0 = lockout (output follows the first edge, then ignores input for the window); 1 = integrate (output changes only after input is stable for the window).
REQ-005 The port list SHALL be, in this order (name, direction, width, meaning):
  clk   input   1          single clock; all state updates on its rising edge
  rst   input   1          asynchronous, active-low reset
  in    input   CHANNELS   raw, asynchronous switch inputs
  out   output  CHANNELS   debounced levels, registered
  rise  output  CHANNELS   one-cycle pulse when out[i] goes 0->1, registered
  fall  output  CHANNELS   one-cycle pulse when out[i] goes 1->0, registered
  busy  output  CHANNELS   high while channel i is in state CHECK

Function
REQ-006 Each in[i] SHALL pass through a two-flop synchronizer; s[i] denotes the second flop's output.
REQ-007 Every channel SHALL be fully independent: it has its own synchronizer, counter, state register and outputs, and no channel affects another.
REQ-008 Each channel SHALL implement an FSM with two states: IDLE (counter = 0, busy = 0) and CHECK (busy = 1).
REQ-009 The counter SHALL saturate at STABLE and SHALL never wrap.
REQ-010 MODE 0, in IDLE with s != out: at the next edge, out <= s, the matching rise or fall pulse is asserted, the state goes to CHECK and the counter goes to 1.
REQ-011 MODE 0, in CHECK: s is ignored and the counter increments each cycle; at the edge where the counter equals STABLE, the state goes to IDLE and the counter goes to 0. busy is therefore high for exactly STABLE cycles.
REQ-012 MODE 0 latency: a clean edge on in[i] SHALL appear on out[i] 3 cycles later (2 synchronizer cycles + 1 register cycle).
REQ-013 MODE 1, in IDLE with s != out: the state goes to CHECK and the counter goes to 1; out does not change.
REQ-014 MODE 1, in CHECK with s == out: the glitch is rejected; the state goes to IDLE, the counter goes to 0, no pulse is generated and out does not change.
REQ-015 MODE 1, in CHECK with s != out and counter == STABLE: at that edge, out <= s, the pulse is asserted, and the state goes to IDLE with the counter at 0.
REQ-016 MODE 1, in CHECK with s != out and counter < STABLE: the counter increments.
REQ-017 MODE 1 latency: a clean edge SHALL appear on out 2 + STABLE + 1 cycles after in changes.
REQ-018 If s differs from out when a channel returns to IDLE, a new event SHALL start on the next cycle, so no edge is lost.
REQ-019 rise and fall SHALL each be high for exactly one cycle per out change, coincident with the first cycle of the new out value; rise and fall SHALL never be high together on the same channel.
REQ-020 With STABLE = 1: MODE 0 busy is high for 1 cycle; MODE 1 requires 2 consecutive differing samples.

Reset
REQ-021 While rst = 0, asynchronously and independent of clk: out, rise, fall, busy, all counters and all synchronizer flops SHALL be 0, and every FSM SHALL be in IDLE.
REQ-022 Reset asserted mid-CHECK SHALL abort the event with no pulse.
REQ-023 After rst deasserts, a channel whose in is held at 1 SHALL be processed as a normal 0->1 event, producing a rise pulse after the latency given in REQ-012 or REQ-017.

Verification (CHANNELS = 4, CNTSIZE = 3, STABLE = 5)
REQ-024 MODE 0, in[0] goes 0->1 cleanly at cycle 10 -> out[0] = 1 and a single rise[0] pulse at cycle 13; busy[0] high for cycles 13 to 17; channels 1 to 3 unchanged.
REQ-025 MODE 0, in[0] bounces 1,0,1,0,1 over 5 cycles and then holds 1 -> exactly one rise[0], no fall[0], and out[0] stays 1 throughout.
REQ-026 MODE 1, in[2] high for 3 cycles then low -> out[2] stays 0, no pulses; busy[2] rises and then drops.
REQ-027 MODE 1, in[1] goes 0->1 at cycle 10 and is held -> out[1] = 1 and a single rise[1] at cycle 18; a 1->0 change held later produces a single fall[1] with the same 8-cycle latency.
REQ-028 MODE 0, in[1] rises and in[3] falls in the same cycle (out[3] previously 1) -> rise[1] and fall[3] are asserted in the same cycle.
REQ-029 rst pulled low during CHECK on channel 0, with in[0] held at 1 -> all outputs are 0 immediately without waiting for a clk edge; after release, rise[0] occurs 3 cycles later (MODE 0).

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: per-channel two-flop synchronizer plus a
// two-state FSM in lockout (MODE 0) or integrate (MODE 1) form.
module debounce_multi #(
    parameter int CHANNELS = 4,
    parameter int CNTSIZE  = 3,
    parameter int STABLE   = 5,
    parameter int MODE     = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    localparam logic [CNTSIZE-1:0] LIMIT = CNTSIZE'(STABLE);
    localparam logic [CNTSIZE-1:0] ONE   = CNTSIZE'(1);

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            logic               sync1;
            logic               sync2;
            state_t             st;
            state_t             st_n;
            logic [CNTSIZE-1:0] cnt;
            logic [CNTSIZE-1:0] cnt_n;
            logic               lvl;
            logic               lvl_n;
            logic               rp;
            logic               rp_n;
            logic               fp;
            logic               fp_n;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1 <= 1'b0;
                    sync2 <= 1'b0;
                    st    <= IDLE;
                    cnt   <= '0;
                    lvl   <= 1'b0;
                    rp    <= 1'b0;
                    fp    <= 1'b0;
                end else begin
                    sync1 <= in[i];
                    sync2 <= sync1;
                    st    <= st_n;
                    cnt   <= cnt_n;
                    lvl   <= lvl_n;
                    rp    <= rp_n;
                    fp    <= fp_n;
                end
            end

            always_comb begin
                st_n  = st;
                cnt_n = cnt;
                lvl_n = lvl;
                rp_n  = 1'b0;
                fp_n  = 1'b0;
                unique case (st)
                    IDLE: begin
                        cnt_n = '0;
                        if (sync2 != lvl) begin
                            st_n  = CHECK;
                            cnt_n = ONE;
                            // Lockout commits the new level on the first edge.
                            if (MODE == 0) begin
                                lvl_n = sync2;
                                rp_n  = sync2;
                                fp_n  = ~sync2;
                            end
                        end
                    end
                    CHECK: begin
                        if (MODE == 0) begin
                            if (cnt == LIMIT) begin
                                st_n  = IDLE;
                                cnt_n = '0;
                            end else begin
                                cnt_n = cnt + ONE;
                            end
                        end else if (sync2 == lvl) begin
                            st_n  = IDLE;
                            cnt_n = '0;
                        end else if (cnt == LIMIT) begin
                            st_n  = IDLE;
                            cnt_n = '0;
                            lvl_n = sync2;
                            rp_n  = sync2;
                            fp_n  = ~sync2;
                        end else begin
                            cnt_n = cnt + ONE;
                        end
                    end
                    default: begin
                        st_n  = IDLE;
                        cnt_n = '0;
                    end
                endcase
            end

            assign out[i]  = lvl;
            assign rise[i] = rp;
            assign fall[i] = fp;
            assign busy[i] = (st == CHECK);
        end
    endgenerate

endmodule
